bin20_to_6bcd: RTL and testbench

BIN20_TO_6BCD -- requirements
Module: bin20_to_6bcd

---
 rtl/bin20_to_6bcd_if.sv | 23 ++
 rtl/bin20_to_6bcd.sv | 150 +++++++++++++++
 tb/tb_bin20_to_6bcd.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bin20_to_6bcd_if.sv
// Handshake, result and display bundle for the 20-bit binary to 6-digit BCD converter.
// The master drives start/binary. The slave (the converter) drives status, digits and segments.
interface bin20_to_6bcd_if;
  logic        start;
  logic [19:0] binary;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  D0, D1, D2, D3, D4, D5;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  modport master (
    output start, binary,
    input  busy, done, ovf, D0, D1, D2, D3, D4, D5,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  start, binary,
    output busy, done, ovf, D0, D1, D2, D3, D4, D5,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/bin20_to_6bcd.sv
// Serial 20-bit binary to 6-digit BCD converter (double dabble), saturating at 999999, with 7-segment outputs.
// Optional macro BIN20_LEADING_BLANK_EN blanks leading zero digits HEX5..HEX1.
module bin20_to_6bcd #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic             VGA_CLK,
  input logic             reset,
  bin20_to_6bcd_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;

  state_t      state_reg;
  logic [19:0] bin_reg;
  logic [23:0] bcd_reg;
  logic [4:0]  cnt_reg;
  logic        sat_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        ovf_reg;
  logic [3:0]  digit_reg [6];
  logic [23:0] bcd_adj;
  logic [3:0]  disp [6];
  logic        blank [6];
  logic [6:0]  hex [6];

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                               : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      sat_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      for (int i = 0; i < 6; i++) digit_reg[i] <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            bin_reg   <= bus.binary;
            sat_reg   <= (bus.binary > 20'd999999);
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // A carry out of the top digit can only mean a seventh digit, i.e. overflow.
          sat_reg   <= sat_reg | bcd_adj[23];
          bcd_reg   <= {bcd_adj[22:0], bin_reg[19]};
          bin_reg   <= {bin_reg[18:0], 1'b0};
          cnt_reg   <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd19) state_reg <= S_LOAD;
        end
        S_LOAD: begin
          for (int i = 0; i < 6; i++)
            digit_reg[i] <= sat_reg ? 4'd9 : bcd_reg[i*4 +: 4];
          ovf_reg   <= sat_reg;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.D0   = digit_reg[0];
  assign bus.D1   = digit_reg[1];
  assign bus.D2   = digit_reg[2];
  assign bus.D3   = digit_reg[3];
  assign bus.D4   = digit_reg[4];
  assign bus.D5   = digit_reg[5];

  // Segments decode from the digit ports so the display always matches what is presented.
  assign disp[0] = bus.D0;
  assign disp[1] = bus.D1;
  assign disp[2] = bus.D2;
  assign disp[3] = bus.D3;
  assign disp[4] = bus.D4;
  assign disp[5] = bus.D5;

  function automatic logic [6:0] seg_low(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign blank[0] = 1'b0;
`ifdef BIN20_LEADING_BLANK_EN
  assign blank[5] = (disp[5] == 4'd0);
  generate
    for (gi = 1; gi < 5; gi++) begin : g_blank
      assign blank[gi] = (disp[gi] == 4'd0) && blank[gi+1];
    end
  endgenerate
`else
  generate
    for (gi = 1; gi < 6; gi++) begin : g_noblank
      assign blank[gi] = 1'b0;
    end
  endgenerate
`endif

  generate
    for (gi = 0; gi < 6; gi++) begin : g_seg
      logic [6:0] pat_low;
      assign pat_low = blank[gi] ? 7'b1111111 : seg_low(disp[gi]);
      assign hex[gi] = SEG_ACTIVE_LOW ? pat_low : ~pat_low;
    end
  endgenerate

  assign bus.HEX0 = hex[0];
  assign bus.HEX1 = hex[1];
  assign bus.HEX2 = hex[2];
  assign bus.HEX3 = hex[3];
  assign bus.HEX4 = hex[4];
  assign bus.HEX5 = hex[5];

endmodule

// File: tb/tb_bin20_to_6bcd.sv
// Self-checking bench for bin20_to_6bcd: directed and random conversions against a decimal arithmetic model.
module tb_bin20_to_6bcd;

  logic VGA_CLK = 1'b0;
  logic reset   = 1'b1;
  always #5 VGA_CLK = ~VGA_CLK;

  bin20_to_6bcd_if bus ();

  bin20_to_6bcd #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [3:0] d_obs [6];
  logic [6:0] h_obs [6];
  assign d_obs[0] = bus.D0;  assign h_obs[0] = bus.HEX0;
  assign d_obs[1] = bus.D1;  assign h_obs[1] = bus.HEX1;
  assign d_obs[2] = bus.D2;  assign h_obs[2] = bus.HEX2;
  assign d_obs[3] = bus.D3;  assign h_obs[3] = bus.HEX3;
  assign d_obs[4] = bus.D4;  assign h_obs[4] = bus.HEX4;
  assign d_obs[5] = bus.D5;  assign h_obs[5] = bus.HEX5;

  logic [3:0] force_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_val(input int v);
    return (v > 999999) ? 999999 : v;
  endfunction

  function automatic int exp_digit(input int v, input int i);
    int s = sat_val(v);
    for (int k = 0; k < i; k++) s = s / 10;
    return s % 10;
  endfunction

  function automatic logic [6:0] exp_hex(input int v, input int i);
    int p = 1;
    bit blank = 1'b0;
    for (int k = 0; k < i; k++) p = p * 10;
`ifdef BIN20_LEADING_BLANK_EN
    blank = (i > 0) && (sat_val(v) < p);
`endif
    if (blank) return 7'b1111111;
    return seg_tab[exp_digit(v, i)];
  endfunction

  task automatic check_result(input int v);
    chk("ovf", {31'd0, bus.ovf}, (v > 999999) ? 32'd1 : 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("D%0d(%0d)", i, v), {28'd0, d_obs[i]}, exp_digit(v, i));
      chk($sformatf("HEX%0d(%0d)", i, v), {25'd0, h_obs[i]}, {25'd0, exp_hex(v, i)});
    end
    $display("[TB] binary=%0d -> D5..D0=%0d%0d%0d%0d%0d%0d ovf=%0b", v,
             d_obs[5], d_obs[4], d_obs[3], d_obs[2], d_obs[1], d_obs[0], bus.ovf);
  endtask

  // Called at a negedge; leaves the bench at the negedge after the capture edge.
  task automatic start_op(input logic [19:0] v);
    bus.start  = 1'b1;
    bus.binary = v;
    @(posedge VGA_CLK);
    @(negedge VGA_CLK);
    bus.start  = 1'b0;
    bus.binary = 20'($urandom);
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    chk("done_after_start", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 60) begin
      @(posedge VGA_CLK);
      lat++;
      @(negedge VGA_CLK);
      if (bus.done) return;
    end
    lat = -1;
  endtask

  task automatic convert(input int v);
    int lat;
    start_op(20'(v));
    wait_done(lat);
    chk("latency", lat, 21);
    chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
    check_result(v);
  endtask

  initial begin
    int lat;
    int pulses;
    bus.start  = 1'b0;
    bus.binary = '0;

    // Asynchronous reset before any clock edge
    #3;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_ovf",  {31'd0, bus.ovf},  32'd0);
    for (int i = 0; i < 6; i++) chk($sformatf("rst_D%0d", i), {28'd0, d_obs[i]}, 32'd0);
    @(negedge VGA_CLK);
    @(negedge VGA_CLK);
    reset = 1'b0;

    convert(0);
    convert(640);
    convert(123456);

    // Back-to-back: the second start is presented in the done cycle
    convert(999999);
    convert(1048575);
    convert(1000000);

    // Start pulse mid-conversion is ignored and the captured operand is kept
    start_op(20'd123456);
    repeat (4) @(posedge VGA_CLK);
    @(negedge VGA_CLK);
    bus.start  = 1'b1;
    bus.binary = 20'd7;
    @(posedge VGA_CLK);
    @(negedge VGA_CLK);
    bus.start  = 1'b0;
    wait_done(lat);
    chk("latency_ignored_start", lat, 16);
    check_result(123456);
    pulses = 0;
    repeat (30) begin
      @(negedge VGA_CLK);
      if (bus.done) pulses++;
    end
    chk("extra_done_pulses", pulses, 0);
    chk("busy_after_ignored", {31'd0, bus.busy}, 32'd0);

    // Random operands over the whole 20-bit range
    for (int n = 0; n < 10; n++) convert(int'($urandom_range(0, 1048575)));
    convert(987654);

    // Reset mid-conversion aborts with no done pulse
    start_op(20'd54321);
    repeat (9) @(posedge VGA_CLK);
    @(negedge VGA_CLK);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_ovf", {31'd0, bus.ovf}, 32'd0);
    for (int i = 0; i < 6; i++) chk($sformatf("abort_D%0d", i), {28'd0, d_obs[i]}, 32'd0);
    @(negedge VGA_CLK);
    reset = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge VGA_CLK);
      if (bus.done) pulses++;
    end
    chk("abort_done_pulses", pulses, 0);
    convert(42);

    // Hex letters on HEX0 by overriding the digit
    for (int v = 10; v < 16; v++) begin
      force_val = 4'(v);
      force bus.D0 = force_val;
      #1;
      chk($sformatf("HEX0_letter_%0h", v), {25'd0, bus.HEX0}, {25'd0, seg_tab[v]});
      $display("[TB] forced D0=%0h -> HEX0=%07b", force_val, bus.HEX0);
      release bus.D0;
    end
    #1;
    chk("HEX0_after_release", {25'd0, bus.HEX0}, {25'd0, exp_hex(42, 0)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
